barrel_seq_ctrl: RTL and testbench

- Sequencer that owns the 8-bit shift register feeding the board's combinational barrel shifter and repeatedly applies it.
- Loads a seed and a latched shift configuration from the switches, then steps the shifter once per debounced button press, or periodically in auto mode.
- Each shifter result is written back into the register.
- Sits between board I/O (buttons, switches) and the barrel shifter; its outputs drive the LEDs and seven-segment decoders.

---
 rtl/barrel_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_barrel_seq_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/barrel_seq_ctrl.sv
// Sequencer around an external combinational barrel shifter: debounced load/step buttons,
// latched shift configuration, single-step and timed auto-step modes with write-back into q.
module barrel_seq_ctrl #(
  parameter int unsigned DEB_CYCLES  = 1000000,
  parameter int unsigned TICK_CYCLES = 25000000,
  parameter int unsigned MAX_STEPS   = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_load,
  input  logic       btn_step,
  input  logic       auto_en,
  input  logic [9:0] sw,
  output logic [7:0] sh_din,
  output logic [2:0] sh_shamt,
  output logic [1:0] sh_ctrl,
  input  logic [7:0] sh_dout,
  output logic [7:0] q,
  output logic [7:0] step_cnt,
  output logic       busy,
  output logic       done
);

  localparam int unsigned DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned TW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  typedef enum logic {IDLE, AUTO} state_t;

  state_t        state;
  logic [1:0]    btn_raw, sync1, sync2, deb, deb_d;
  logic [DW-1:0] dcnt [2];
  logic [TW-1:0] tick;
  logic [2:0]    cfg_shamt;
  logic [1:0]    cfg_ctrl;
  logic [7:0]    cnt_inc;
  logic          load_p, step_p;

  assign btn_raw = {btn_step, btn_load};

  // Index 0 is load, index 1 is step. The counter only runs while the synchronised
  // level disagrees with the debounced level, so any bounce back restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      dcnt  <= '{default: '0};
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      deb_d <= deb;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DW'(DEB_CYCLES - 1)) begin
          deb[i]  <= sync2[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + DW'(1);
        end
      end
    end
  end

  assign load_p  = deb[0] & ~deb_d[0];
  assign step_p  = deb[1] & ~deb_d[1];
  assign cnt_inc = (step_cnt == 8'hFF) ? step_cnt : step_cnt + 8'd1;

  assign sh_din   = q;
  assign sh_shamt = cfg_shamt;
  assign sh_ctrl  = cfg_ctrl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      q         <= '0;
      cfg_shamt <= '0;
      cfg_ctrl  <= '0;
      step_cnt  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      tick      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_p) begin
            q         <= sw[7:0];
            step_cnt  <= '0;
            cfg_shamt <= sw[2:0];
            cfg_ctrl  <= sw[9:8];
          end else if (step_p) begin
            if (auto_en) begin
              tick  <= '0;
              busy  <= 1'b1;
              state <= AUTO;
            end else begin
              q        <= sh_dout;
              step_cnt <= cnt_inc;
            end
          end
        end
        AUTO: begin
          if (load_p) begin
            q         <= sw[7:0];
            step_cnt  <= '0;
            cfg_shamt <= sw[2:0];
            cfg_ctrl  <= sw[9:8];
            busy      <= 1'b0;
            state     <= IDLE;
          end else if (step_p || !auto_en) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tick == TW'(TICK_CYCLES - 1)) begin
            tick     <= '0;
            q        <= sh_dout;
            step_cnt <= cnt_inc;
            // Termination is judged on the values being written this cycle.
            if (sh_dout == 8'h00 || cnt_inc == 8'(MAX_STEPS)) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            tick <= tick + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_barrel_seq_ctrl.sv
// Directed bench for barrel_seq_ctrl with a behavioural barrel shifter on the sh_* ports;
// short debounce and tick periods keep runs brief.
module tb_barrel_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn_load, btn_step, auto_en;
  logic [9:0] sw;
  logic [7:0] sh_din, sh_dout, q, step_cnt;
  logic [2:0] sh_shamt;
  logic [1:0] sh_ctrl;
  logic       busy, done;
  logic [15:0] rot16;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned done_cnt = 0;
  logic [7:0]  exp_q [8] = '{8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h00};

  barrel_seq_ctrl #(.DEB_CYCLES(4), .TICK_CYCLES(3), .MAX_STEPS(255)) dut (
    .clk(clk), .rst_n(rst_n), .btn_load(btn_load), .btn_step(btn_step),
    .auto_en(auto_en), .sw(sw), .sh_din(sh_din), .sh_shamt(sh_shamt),
    .sh_ctrl(sh_ctrl), .sh_dout(sh_dout), .q(q), .step_cnt(step_cnt),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Board barrel shifter: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
  assign rot16 = {sh_din, sh_din} << sh_shamt;
  always_comb begin
    sh_dout = 8'h00;
    case (sh_ctrl)
      2'b00: sh_dout = sh_din << sh_shamt;
      2'b01: sh_dout = sh_din >> sh_shamt;
      2'b10: sh_dout = 8'($signed(sh_din) >>> sh_shamt);
      2'b11: sh_dout = rot16[15:8];
      default: sh_dout = 8'h00;
    endcase
  end

  always @(negedge clk) if (rst_n && done === 1'b1) done_cnt++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic press(input logic l, input logic s);
    btn_load = l;
    btn_step = s;
    repeat (12) @(negedge clk);
    btn_load = 1'b0;
    btn_step = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int unsigned d0, k, last_t;
    logic [7:0]  prev;
    logic        got;

    rst_n = 1'b0; btn_load = 1'b0; btn_step = 1'b0; auto_en = 1'b0; sw = '0;
    repeat (3) @(negedge clk);
    check("rst_q", q, 8'h00);
    check("rst_cnt", step_cnt, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Load 0x91, shamt 1, SLL; first step through a bouncing button.
    sw = 10'b00_1001_0001;
    press(1'b1, 1'b0);
    check("load_q", q, 8'h91);
    check("load_shamt", sh_shamt, 3'd1);
    for (int i = 0; i < 10; i++) begin
      btn_step = ~btn_step;
      @(negedge clk);
    end
    check("bounce_q", q, 8'h91);
    btn_step = 1'b1;
    repeat (20) @(negedge clk);
    check("deb_q", q, 8'h22);
    check("deb_cnt", step_cnt, 8'd1);
    btn_step = 1'b0;
    repeat (10) @(negedge clk);
    press(1'b0, 1'b1);
    check("sll_q2", q, 8'h44);
    press(1'b0, 1'b1);
    check("sll_q3", q, 8'h88);
    check("sll_cnt", step_cnt, 8'd3);

    // Rotate left 3 with the switches cleared after the load.
    sw = 10'b11_1000_0011;
    press(1'b1, 1'b0);
    sw = '0;
    press(1'b0, 1'b1);
    check("rol_q1", q, 8'h1C);
    press(1'b0, 1'b1);
    check("rol_q2", q, 8'hE0);
    check("rol_cnt", step_cnt, 8'd2);

    // Auto run: 0x81 SRL 1 until q reaches zero.
    sw = 10'b01_1000_0001;
    press(1'b1, 1'b0);
    auto_en = 1'b1;
    d0 = done_cnt; k = 0; last_t = 0; prev = q; got = 1'b0;
    btn_step = 1'b1;
    for (int unsigned c = 0; c < 150 && !got; c++) begin
      @(negedge clk);
      if (q !== prev) begin
        if (k < 8) check("auto_q", q, exp_q[k]);
        if (k > 0) check("auto_gap", c - last_t, 3);
        last_t = c; k++; prev = q;
      end
      if (done === 1'b1) begin
        got = 1'b1;
        check("auto_done_q", q, 8'h00);
        check("auto_done_cnt", step_cnt, 8'd8);
        check("auto_done_busy", busy, 1'b0);
      end
    end
    if (!got) check("auto_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("auto_done_width", done, 1'b0);
    btn_step = 1'b0;
    repeat (10) @(negedge clk);
    check("auto_steps", k, 8);
    check("auto_done_pulses", done_cnt - d0, 1);

    // shamt 0: q holds while the run goes to the step limit.
    sw = 10'b11_1111_1000;
    press(1'b1, 1'b0);
    d0 = done_cnt; got = 1'b0;
    btn_step = 1'b1;
    for (int unsigned c = 0; c < 1000 && !got; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        got = 1'b1;
        check("max_cnt", step_cnt, 8'd255);
        check("max_q", q, 8'hF8);
      end
    end
    if (!got) check("max_timeout", 32'd0, 32'd1);
    btn_step = 1'b0;
    repeat (10) @(negedge clk);
    check("max_pulses", done_cnt - d0, 1);

    // Load and step together mid-run: load wins, no done.
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("prio_busy_before", busy, 1'b1);
    d0 = done_cnt;
    sw = 10'b00_0101_0101;
    press(1'b1, 1'b1);
    check("prio_q", q, 8'h55);
    check("prio_cnt", step_cnt, 8'd0);
    check("prio_busy", busy, 1'b0);
    check("prio_shamt", sh_shamt, 3'd5);
    check("prio_ctrl", sh_ctrl, 2'd0);
    check("prio_no_done", done_cnt - d0, 0);

    // Asynchronous reset in the middle of an auto run.
    sw = 10'b11_1111_1000;
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    check("mid_busy", busy, 1'b1);
    check("mid_q", q, 8'hF8);
    check("mid_cnt_nz", step_cnt != 8'd0, 1'b1);
    d0 = done_cnt;
    #2 rst_n = 1'b0;
    #1;
    check("arst_q", q, 8'h00);
    check("arst_cnt", step_cnt, 8'h00);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    check("arst_shamt", sh_shamt, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("post_q", q, 8'h00);
    check("post_cnt", step_cnt, 8'h00);
    check("post_busy", busy, 1'b0);
    check("post_no_done", done_cnt - d0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
